// File: rtl/pool_pkg.sv
// Shared definitions for the pooling PISO feeder: FSM state encoding and
// the element-slicing helper used to pick one OP_WIDTH lane out of a word.
package pool_pkg;

    // Shifter occupancy: EMPTY holds nothing, ACTIVE is presenting an element.
    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Bit offset of element idx inside a packed word (LSB-first lanes).
    function automatic int unsigned elem_lsb(input int unsigned idx,
                                             input int unsigned op_width);
        return idx * op_width;
    endfunction

endpackage

// File: rtl/pool_piso_feeder_if.sv
// Stream bundle for the PISO feeder: packed-word input handshake from the
// memory-controller write stream and serial element output toward pooling.
interface pool_piso_feeder_if #(
    parameter int OP_WIDTH = 16,
    parameter int NUM_PE   = 4
);
    logic [OP_WIDTH*NUM_PE-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [OP_WIDTH-1:0]        out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    // Producer/consumer side: drives words in, accepts elements out.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    // Feeder side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/pool_skid_reg.sv
// One-entry skid register: holds a word that arrived while the shifter was
// still busy, with a full flag that qualifies the payload.
module pool_skid_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    // Occupancy flag; load and clear never coincide, load wins if they do.
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

    // Payload capture.
    // NOTE: the data register is deliberately not reset; full gates every use of it.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/pool_piso_feeder.sv
// Parallel-in/serial-out feeder: accepts NUM_PE-element packed words and
// emits one element per cycle, LSB element first, flagging the last one.
// A one-word skid keeps the stream bubble-free across word boundaries.
module pool_piso_feeder
    import pool_pkg::*;
#(
    parameter int OP_WIDTH = 16,
    parameter int NUM_PE   = 4
) (
    input  logic              clk,
    input  logic              reset,
    pool_piso_feeder_if.slave bus,
    output logic              busy
);

    localparam int WORD_WIDTH = OP_WIDTH * NUM_PE;
    localparam int IDX_WIDTH  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PE - 1);

    state_t                  state;
    state_t                  state_next;
    logic [IDX_WIDTH-1:0]    idx;
    logic [IDX_WIDTH-1:0]    idx_next;
    logic [WORD_WIDTH-1:0]   shifter;
    logic [WORD_WIDTH-1:0]   shifter_next;

    logic                    ready;
    logic                    valid;
    logic                    in_fire;
    logic                    out_fire;
    logic                    at_last;
    logic                    skid_full;
    logic                    skid_load;
    logic                    skid_clear;
    logic [WORD_WIDTH-1:0]   skid_data;

    // Ready depends only on registered skid state (and reset), never on out_ready.
    assign ready        = !skid_full && !reset;
    assign valid        = (state == ST_ACTIVE);
    assign at_last      = (idx == LAST_IDX);
    assign in_fire      = bus.in_valid && ready;
    assign out_fire     = valid && bus.out_ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_last  = valid && at_last;
    assign bus.out_data  = valid ? shifter[elem_lsb(32'(idx), OP_WIDTH) +: OP_WIDTH]
                                 : '0;
    assign busy          = valid || skid_full;

    pool_skid_reg #(
        .WIDTH (WORD_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (bus.in_data),
        .data      (skid_data),
        .full      (skid_full)
    );

    // Next-state, element index, shifter reload and skid control.
    // NOTE: every signal gets its hold/idle value first so no path infers a latch.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        shifter_next = shifter;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    shifter_next = bus.in_data;
                    idx_next     = '0;
                    state_next   = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (out_fire) begin
                    if (!at_last) begin
                        idx_next = idx + 1'b1;
                    end else if (skid_full) begin
                        // Skid drains first; ready is low so no input this cycle.
                        shifter_next = skid_data;
                        idx_next     = '0;
                        skid_clear   = 1'b1;
                    end else if (in_fire) begin
                        // Direct reload keeps the skid empty.
                        shifter_next = bus.in_data;
                        idx_next     = '0;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
                // A word arriving mid-word parks in the skid.
                if (in_fire && !(out_fire && at_last)) begin
                    skid_load = 1'b1;
                end
            end

            default: state_next = ST_EMPTY;
        endcase
    end

    // Control state: reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Shifter payload; only read while ACTIVE, so it carries no reset.
    always_ff @(posedge clk) begin
        shifter <= shifter_next;
    end

endmodule

// File: tb/tb_pool_piso_feeder.sv
// Self-checking bench for pool_piso_feeder: directed phases plus a random
// valid/ready stream, with a queue-based scoreboard fed on every accepted word.
module tb_pool_piso_feeder;

    localparam int OP  = 16;
    localparam int NPE = 4;

    typedef struct packed {
        logic [OP-1:0] data;
        logic          last;
    } elem_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic busy1;

    always #5 clk = ~clk;

    pool_piso_feeder_if #(.OP_WIDTH(OP), .NUM_PE(NPE)) bus ();
    pool_piso_feeder_if #(.OP_WIDTH(OP), .NUM_PE(1))   bus1 ();

    pool_piso_feeder #(.OP_WIDTH(OP), .NUM_PE(NPE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    pool_piso_feeder #(.OP_WIDTH(OP), .NUM_PE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1),
        .busy  (busy1)
    );

    elem_t exp_q[$];
    elem_t mon_e;
    int    n_checks    = 0;
    int    n_pass      = 0;
    int    n_pushed    = 0;
    int    n_popped    = 0;
    int    n_discarded = 0;
    bit    rand_done   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a word becomes NUM_PE elements, lowest lane first,
    // only the top lane marked last.
    task automatic push_word(input logic [OP*NPE-1:0] w);
        elem_t e;
        for (int k = 0; k < NPE; k++) begin
            e.data = w[k*OP +: OP];
            e.last = (k == NPE - 1);
            exp_q.push_back(e);
            n_pushed++;
        end
    endtask

    // Monitor: away from the active edge, pop/compare each output transfer,
    // push the model's expectation for each accepted input word.
    always @(negedge clk) begin
        if (reset) begin
            n_discarded += exp_q.size();
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_data", bus.out_data, mon_e.data);
                    check("sb_last", bus.out_last, mon_e.last);
                    n_popped++;
                end
            end
            if (bus.in_valid && bus.in_ready) push_word(bus.in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [OP*NPE-1:0] w, input string name);
        int budget = 200;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        while (!bus.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({name, "_accepted"}, (budget > 0), 1);
        tick();
    endtask

    task automatic wait_idle(input string name);
        int budget = 100;
        @(negedge clk);
        while (busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, busy, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [OP*NPE-1:0] wa, wb, wc, wd, we;
        int budget, gaps, lasts, tries;
        bit accepted;

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b1;
        reset          = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last",  bus.out_last, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_busy",      busy, 0);
        check("rst_in_ready",  bus.in_ready, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_release", bus.in_ready, 1);

        // Single word, 1-cycle latency, LSB element first
        tick();
        bus.out_ready = 1'b1;
        send(64'h0004_0003_0002_0001, "single");
        bus.in_valid = 1'b0;
        for (int i = 0; i < NPE; i++) begin
            @(negedge clk);
            check("single_valid", bus.out_valid, 1);
            check("single_data",  bus.out_data, i + 1);
            check("single_last",  bus.out_last, (i == NPE - 1));
        end
        @(negedge clk);
        check("single_done_valid", bus.out_valid, 0);
        check("single_done_busy",  busy, 0);

        // Back-to-back words: contiguous output, last on every 4th element
        tick();
        fork
            begin
                send(64'h1004_1003_1002_1001, "b2b0");
                send(64'h2004_2003_2002_2001, "b2b1");
                send(64'h3004_3003_3002_3001, "b2b2");
                bus.in_valid = 1'b0;
            end
            begin
                budget = 20;
                gaps   = 0;
                lasts  = 0;
                @(negedge clk);
                while (!bus.out_valid && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                check("b2b_started", (budget > 0), 1);
                for (int i = 0; i < 3 * NPE; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!bus.out_valid) gaps++;
                    if (bus.out_valid && bus.out_last) begin
                        lasts++;
                        check("b2b_last_position", i % NPE, NPE - 1);
                    end
                end
                check("b2b_gaps",  gaps, 0);
                check("b2b_lasts", lasts, 3);
                @(negedge clk);
                check("b2b_idle_after", bus.out_valid, 0);
            end
        join

        // Backpressure: hold element 2, second word parks in skid, third waits
        tick();
        wa = 64'h0004_0003_0002_0001;
        wb = 64'h0014_0013_0012_0011;
        wc = 64'h0024_0023_0022_0021;
        send(wa, "bp_a");
        send(wb, "bp_b");
        bus.in_data  = wc;
        bus.in_valid = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_data",  bus.out_data, 3);
            check("bp_hold_last",  bus.out_last, 0);
            check("bp_skid_ready", bus.in_ready, 0);
            check("bp_busy",       busy, 1);
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_data", bus.out_data, 3);
        @(negedge clk);
        check("bp_last_data",      bus.out_data, 4);
        check("bp_last_flag",      bus.out_last, 1);
        check("bp_c_still_blocked", bus.in_ready, 0);
        @(negedge clk);
        check("bp_ready_after_drain", bus.in_ready, 1);
        check("bp_b_first_elem",      bus.out_data, 16'h0011);
        tick();
        bus.in_valid = 1'b0;
        wait_idle("bp_drained");

        // Reset mid-word: partial word discarded, next word starts at element 0
        wd = 64'h0044_0043_0042_0041;
        we = 64'h0054_0053_0052_0051;
        send(wd, "rst_d");
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_out_valid", bus.out_valid, 0);
        check("rstmid_busy",      busy, 0);
        check("rstmid_in_ready",  bus.in_ready, 0);
        tick();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        send(we, "rst_e");
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rstmid_first_elem", bus.out_data, we[OP-1:0]);
        wait_idle("rstmid_drained");

        // Random valid/ready traffic, 200 words against the scoreboard
        fork
            begin
                for (int w = 0; w < 200; w++) begin
                    bus.in_data = {$urandom, $urandom};
                    accepted    = 1'b0;
                    tries       = 0;
                    while (!accepted && tries < 200) begin
                        bus.in_valid = ($urandom_range(0, 3) != 0);
                        @(negedge clk);
                        accepted = bus.in_valid && bus.in_ready;
                        tick();
                        tries++;
                    end
                    if (!accepted) check("rand_accept_timeout", 0, 1);
                end
                bus.in_valid = 1'b0;
                rand_done    = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_idle("rand_drained");
        check("sb_queue_empty", exp_q.size(), 0);
        check("sb_element_count", n_popped, n_pushed - n_discarded);

        // NUM_PE=1 instance: every element is last, direct reloads back-to-back
        bus1.in_valid = 1'b1;
        bus1.in_data  = 16'h000A;
        @(negedge clk);
        check("pe1_ready_a", bus1.in_ready, 1);
        tick();
        bus1.in_data = 16'h000B;
        @(negedge clk);
        check("pe1_data_a",  bus1.out_data, 16'h000A);
        check("pe1_last_a",  bus1.out_last, 1);
        check("pe1_ready_b", bus1.in_ready, 1);
        tick();
        bus1.in_data = 16'h000C;
        @(negedge clk);
        check("pe1_data_b",  bus1.out_data, 16'h000B);
        check("pe1_last_b",  bus1.out_last, 1);
        check("pe1_ready_c", bus1.in_ready, 1);
        tick();
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("pe1_data_c",  bus1.out_data, 16'h000C);
        check("pe1_last_c",  bus1.out_last, 1);
        check("pe1_valid_c", bus1.out_valid, 1);
        @(negedge clk);
        check("pe1_idle", bus1.out_valid, 0);
        check("pe1_busy", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
